// File: rtl/sif_address_shifter.sv
// sif_address_shifter
// Serial address loader for the sensor-interface analog multiplexers.
// One frame holds N_TX transmit addresses and one receive address, with tx[0]
// in the most significant field and the receive address in the least
// significant field. The frame is shifted out on a divided SPI-style clock and
// closed with a latch strobe. In capacitive mode a frame with two equal transmit
// addresses is refused: the error flag is raised and done_o is pulsed, but no
// clock edge is issued.
// Every output is driven straight from a flop. Each output register is loaded
// with the value it must show in the following cycle.

module sif_address_shifter #(
  parameter int ADDR_W    = 4,
  parameter int N_TX      = 2,
  parameter int CLK_DIV   = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_TX*ADDR_W-1:0]       tx_add_i,
  input  logic [ADDR_W-1:0]            rx_add_i,
  input  logic                         en_i,
  input  logic                         mode_i,
  output logic                         spi_clk_o,
  output logic                         spi_data_o,
  output logic                         spi_latch_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [(N_TX+1)*ADDR_W-1:0]   spi_reg_mon
);

  localparam int FRAME_W = (N_TX + 1) * ADDR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int DIV_W   = $clog2(2 * CLK_DIV + 1);

  // Divider phase constants. One bit lasts 2*CLK_DIV cycles. The clock is high
  // from phase DIV_HALF up to DIV_LAST.
  localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Places tx[0] in the MSBs, tx[N_TX-1] just above the receive field, and
  // rx in the LSBs.
  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic [N_TX*ADDR_W-1:0] tx,
    input logic [ADDR_W-1:0]      rx
  );
    logic [FRAME_W-1:0] f;
    f = '0;
    f[ADDR_W-1:0] = rx;
    for (int k = 0; k < N_TX; k++) begin
      f[FRAME_W-1-k*ADDR_W -: ADDR_W] = tx[k*ADDR_W +: ADDR_W];
    end
    return f;
  endfunction

  // Returns 1 when any two transmit channels hold the same address. Every
  // pair is compared, adjacent or not. With one channel the result is 0.
  function automatic logic has_duplicate(input logic [N_TX*ADDR_W-1:0] tx);
    logic dup;
    dup = 1'b0;
    for (int j = 0; j < N_TX; j++) begin
      for (int k = j + 1; k < N_TX; k++) begin
        if (tx[j*ADDR_W +: ADDR_W] == tx[k*ADDR_W +: ADDR_W]) begin
          dup = 1'b1;
        end else begin
          dup = dup;
        end
      end
    end
    return dup;
  endfunction

  // Returns the bit that goes out first from a register value.
  function automatic logic out_bit(input logic [FRAME_W-1:0] r);
    logic b;
    if (MSB_FIRST != 0) begin
      b = r[FRAME_W-1];
    end else begin
      b = r[0];
    end
    return b;
  endfunction

  state_t             state_r;
  logic [FRAME_W-1:0] spi_reg_r;
  logic [DIV_W-1:0]   div_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               err_r;
  logic               spi_clk_r;
  logic               spi_data_r;
  logic               spi_latch_r;
  logic               busy_r;
  logic               done_r;

  logic [FRAME_W-1:0] frame_s;
  logic               dup_err_s;
  logic [FRAME_W-1:0] shifted_s;
  logic [DIV_W-1:0]   div_inc_s;

  // Builds the candidate frame and the duplicate check from the live inputs.
  // Both are used only on the cycle in which a request is accepted.
  always_comb begin
    frame_s   = pack_frame(tx_add_i, rx_add_i);
    dup_err_s = 1'b0;
    if (mode_i == 1'b0) begin
      dup_err_s = has_duplicate(tx_add_i);
    end else begin
      dup_err_s = 1'b0;
    end
  end

  // Computes the register value after one shift. The vacated bit is filled
  // with zero, so a fully shifted register reads as zero.
  always_comb begin
    shifted_s = spi_reg_r;
    if (MSB_FIRST != 0) begin
      shifted_s = spi_reg_r << 1;
    end else begin
      shifted_s = spi_reg_r >> 1;
    end
  end

  // Computes the next divider phase inside a bit or inside the latch window.
  always_comb begin
    div_inc_s = div_r + DIV_ONE;
  end

  // Control FSM. It also loads the output registers with next cycle's values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      spi_reg_r   <= '0;
      div_r       <= '0;
      cnt_r       <= '0;
      err_r       <= 1'b0;
      spi_clk_r   <= 1'b0;
      spi_data_r  <= 1'b0;
      spi_latch_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          div_r       <= '0;
          cnt_r       <= '0;
          spi_clk_r   <= 1'b0;
          spi_latch_r <= 1'b0;
          if (en_i) begin
            if (dup_err_s) begin
              // Refused frame: no load and no clocks. Report completion at once.
              state_r    <= ST_DONE;
              err_r      <= 1'b1;
              done_r     <= 1'b1;
              busy_r     <= 1'b0;
              spi_data_r <= 1'b0;
            end else begin
              // Accepted frame: the first data bit is valid from the first
              // SHIFT cycle, while the clock is still low.
              state_r    <= ST_SHIFT;
              spi_reg_r  <= frame_s;
              err_r      <= 1'b0;
              done_r     <= 1'b0;
              busy_r     <= 1'b1;
              spi_data_r <= out_bit(frame_s);
            end
          end else begin
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            spi_data_r <= 1'b0;
          end
        end

        ST_SHIFT: begin
          if (div_r == DIV_LAST) begin
            // Last high phase: shift on the falling edge of spi_clk_o.
            div_r     <= '0;
            spi_reg_r <= shifted_s;
            spi_clk_r <= 1'b0;
            if (cnt_r == CNT_LAST) begin
              state_r     <= ST_LATCH;
              cnt_r       <= '0;
              spi_latch_r <= 1'b1;
              spi_data_r  <= 1'b0;
            end else begin
              cnt_r      <= cnt_r + CNT_ONE;
              spi_data_r <= out_bit(shifted_s);
            end
          end else begin
            div_r <= div_inc_s;
            if (div_inc_s >= DIV_HALF) begin
              spi_clk_r <= 1'b1;
            end else begin
              spi_clk_r <= 1'b0;
            end
          end
        end

        ST_LATCH: begin
          spi_clk_r  <= 1'b0;
          spi_data_r <= 1'b0;
          if (div_r == LATCH_LAST) begin
            state_r     <= ST_DONE;
            div_r       <= '0;
            spi_latch_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
          end else begin
            div_r       <= div_inc_s;
            spi_latch_r <= 1'b1;
          end
        end

        ST_DONE: begin
          // Exactly one DONE cycle, then back to IDLE. The error flag is held.
          state_r     <= ST_IDLE;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          spi_clk_r   <= 1'b0;
          spi_data_r  <= 1'b0;
          spi_latch_r <= 1'b0;
        end

        default: begin
          state_r     <= ST_IDLE;
          div_r       <= '0;
          cnt_r       <= '0;
          spi_clk_r   <= 1'b0;
          spi_data_r  <= 1'b0;
          spi_latch_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign spi_clk_o   = spi_clk_r;
  assign spi_data_o  = spi_data_r;
  assign spi_latch_o = spi_latch_r;
  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign err_o       = err_r;
  assign spi_reg_mon = spi_reg_r;

endmodule

// File: tb/tb_sif_address_shifter.sv
// Scoreboard bench for sif_address_shifter.
// DUT A uses the default parameters. DUT B uses ADDR_W=5, N_TX=3, CLK_DIV=3 and
// MSB_FIRST=1. Each stimulus task pushes a hand-computed expectation. A monitor
// samples 1 time unit after each rising clock edge. It collects the serial bits,
// the clock pulses and the latch cycles, and compares them against the
// expectation at the front of the queue whenever done_o is seen.

module tb_sif_address_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A
  logic        rst_a, en_a, mode_a;
  logic [7:0]  tx_a;
  logic [3:0]  rx_a;
  logic        sclk_a, sdat_a, slat_a, busy_a, done_a, err_a;
  logic [11:0] mon_a;

  // DUT B
  logic        rst_b, en_b, mode_b;
  logic [14:0] tx_b;
  logic [4:0]  rx_b;
  logic        sclk_b, sdat_b, slat_b, busy_b, done_b, err_b;
  logic [19:0] mon_b;

  sif_address_shifter dut_a (
    .clk_i(clk), .rst_i(rst_a), .tx_add_i(tx_a), .rx_add_i(rx_a),
    .en_i(en_a), .mode_i(mode_a), .spi_clk_o(sclk_a), .spi_data_o(sdat_a),
    .spi_latch_o(slat_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a),
    .spi_reg_mon(mon_a)
  );

  sif_address_shifter #(.ADDR_W(5), .N_TX(3), .CLK_DIV(3), .MSB_FIRST(1)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .tx_add_i(tx_b), .rx_add_i(rx_b),
    .en_i(en_b), .mode_i(mode_b), .spi_clk_o(sclk_b), .spi_data_o(sdat_b),
    .spi_latch_o(slat_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b),
    .spi_reg_mon(mon_b)
  );

  typedef struct {
    int          t;      // acceptance cycle
    bit          err;
    int          nbits;
    int          cd;
    logic [31:0] bits;   // bits in order of arrival, first bit in the MSB
    logic [31:0] mon;    // spi_reg_mon one cycle after acceptance
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int tests = 0;
  int fails = 0;

  int          rises[2];
  int          hi_cnt[2];
  int          run[2];
  int          lat_cnt[2];
  int          lat_first[2];
  logic [31:0] bits_acc[2];
  bit          prev_clk[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_acc(input int d);
    rises[d] = 0; hi_cnt[d] = 0; run[d] = 0; lat_cnt[d] = 0;
    lat_first[d] = 0; bits_acc[d] = '0; prev_clk[d] = 1'b0;
  endtask

  task automatic mon_step(input int d, input logic rst, input logic sclk, input logic sdat,
                          input logic slat, input logic busy, input logic done,
                          input logic err, input logic [31:0] mon);
    exp_t cur;
    bit   have;
    int   cd;
    have = 1'b0;
    if (d == 0) begin
      have = (q0.size() > 0);
      if (have) cur = q0[0];
    end else begin
      have = (q1.size() > 0);
      if (have) cur = q1[0];
    end
    cd = have ? cur.cd : 0;
    if (rst) begin
      clear_acc(d);
    end else begin
      if (have && cur.nbits > 0 && cyc == cur.t + 1)
        check($sformatf("load_mon%0d", d), mon, cur.mon);
      if (sclk && !prev_clk[d]) begin
        rises[d]++;
        bits_acc[d] = {bits_acc[d][30:0], sdat};
        run[d] = 0;
      end
      if (sclk) begin
        run[d]++;
        hi_cnt[d]++;
        check($sformatf("clk_busy%0d", d), {31'b0, busy}, 32'd1);
      end
      if (!sclk && prev_clk[d])
        check($sformatf("clk_high_width%0d", d), run[d], cd);
      if (slat) begin
        check($sformatf("latch_expected%0d", d), {31'b0, have}, 32'd1);
        if (lat_cnt[d] == 0) lat_first[d] = cyc;
        lat_cnt[d]++;
      end
      if (done) begin
        if (!have) begin
          tests++; fails++;
          $display("FAIL unexpected_done%0d: got done_o=1, expected no done (cycle %0d)", d, cyc);
        end else begin
          if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          check($sformatf("done_cycle%0d", d), cyc,
                cur.err ? cur.t + 1 : cur.t + cur.nbits * 2 * cur.cd + cur.cd + 1);
          check($sformatf("err%0d", d), {31'b0, err}, {31'b0, cur.err});
          check($sformatf("clk_rises%0d", d), rises[d], cur.nbits);
          check($sformatf("clk_high_total%0d", d), hi_cnt[d], cur.nbits * cur.cd);
          check($sformatf("latch_len%0d", d), lat_cnt[d], cur.err ? 0 : cur.cd);
          check($sformatf("busy_in_done%0d", d), {31'b0, busy}, 32'd0);
          if (!cur.err) begin
            check($sformatf("data_bits%0d", d), bits_acc[d], cur.bits);
            check($sformatf("latch_start%0d", d), lat_first[d],
                  cur.t + cur.nbits * 2 * cur.cd + 1);
          end
        end
        clear_acc(d);
      end
      prev_clk[d] = sclk;
    end
  endtask

  // Monitor: sample both DUTs shortly after every active edge.
  always @(posedge clk) begin
    #1;
    mon_step(0, rst_a, sclk_a, sdat_a, slat_a, busy_a, done_a, err_a, {20'b0, mon_a});
    mon_step(1, rst_b, sclk_b, sdat_b, slat_b, busy_b, done_b, err_b, {12'b0, mon_b});
  end

  task automatic start_a(input logic [7:0] tx, input logic [3:0] rx, input logic m,
                         input bit e, input int nb, input logic [31:0] bits,
                         input logic [31:0] mon);
    exp_t x;
    @(negedge clk);
    tx_a = tx; rx_a = rx; mode_a = m; en_a = 1'b1;
    x.t = cyc; x.err = e; x.nbits = nb; x.cd = 1; x.bits = bits; x.mon = mon;
    q0.push_back(x);
    @(negedge clk);
    en_a = 1'b0;
  endtask

  task automatic start_b(input logic [14:0] tx, input logic [4:0] rx, input logic m,
                         input bit e, input int nb, input logic [31:0] bits,
                         input logic [31:0] mon);
    exp_t x;
    @(negedge clk);
    tx_b = tx; rx_b = rx; mode_b = m; en_b = 1'b1;
    x.t = cyc; x.err = e; x.nbits = nb; x.cd = 3; x.bits = bits; x.mon = mon;
    q1.push_back(x);
    @(negedge clk);
    en_b = 1'b0;
  endtask

  task automatic wait_drain(input int d, input int max);
    int left;
    left = (d == 0) ? q0.size() : q1.size();
    for (int i = 0; i < max && left > 0; i++) begin
      @(negedge clk);
      left = (d == 0) ? q0.size() : q1.size();
    end
    if (left > 0) begin
      tests++; fails++;
      $display("FAIL timeout%0d: got %0d pending frames, expected 0", d, left);
      if (d == 0) q0.delete(); else q1.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int t0;
    int ev;
    rst_a = 1'b1; en_a = 1'b0; mode_a = 1'b0; tx_a = '0; rx_a = '0;
    rst_b = 1'b1; en_b = 1'b0; mode_b = 1'b0; tx_b = '0; rx_b = '0;
    for (int i = 0; i < 2; i++) clear_acc(i);
    repeat (3) @(negedge clk);
    check("reset_a", {20'b0, sclk_a, sdat_a, slat_a, busy_a, done_a, err_a, mon_a}, 32'd0);
    check("reset_b", {6'b0, sclk_b, sdat_b, slat_b, busy_b, done_b, err_b, mon_b}, 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // Frame A35, sent LSB first: bits 1010 1100 0101.
    start_a({4'h3, 4'hA}, 4'h5, 1'b0, 1'b0, 12, 32'hAC5, 32'hA35);
    wait_drain(0, 100);

    // Duplicate addresses in capacitive mode take the error path.
    start_a({4'h7, 4'h7}, 4'h5, 1'b0, 1'b1, 0, 32'h0, 32'h0);
    check("err_path_done", {31'b0, done_a}, 32'd1);
    check("err_path_err", {31'b0, err_a}, 32'd1);
    wait_drain(0, 20);
    repeat (5) @(negedge clk);
    check("err_held", {31'b0, err_a}, 32'd1);

    // Same addresses in continuity mode: frame 775 goes out and err clears.
    start_a({4'h7, 4'h7}, 4'h5, 1'b1, 1'b0, 12, 32'hAEE, 32'h775);
    check("err_cleared", {31'b0, err_a}, 32'd0);
    wait_drain(0, 100);

    // Reset after the 5th shift.
    start_a({4'h3, 4'hA}, 4'h5, 1'b0, 1'b0, 12, 32'hAC5, 32'hA35);
    repeat (10) @(negedge clk);
    check("mid_frame_reg", {20'b0, mon_a}, 32'h051);
    rst_a = 1'b1;
    @(negedge clk);
    check("reset_midframe", {20'b0, sclk_a, sdat_a, slat_a, busy_a, done_a, err_a, mon_a}, 32'd0);
    rst_a = 1'b0;
    q0.delete();
    ev = 0;
    repeat (40) begin
      @(negedge clk);
      ev += int'(done_a) + int'(slat_a);
    end
    check("no_pulse_after_reset", ev, 0);

    // A full frame after the reset: C69 gives bits 1001 0110 0011.
    start_a({4'h6, 4'hC}, 4'h9, 1'b0, 1'b0, 12, 32'h963, 32'hC69);
    wait_drain(0, 100);

    // en_i held high: back-to-back frames with one IDLE cycle between them.
    // The inputs change during the first frame and feed only the second one.
    @(negedge clk);
    tx_a = {4'hB, 4'h2}; rx_a = 4'hE; mode_a = 1'b0; en_a = 1'b1;
    t0 = cyc;
    begin
      exp_t x;
      x.t = t0; x.err = 1'b0; x.nbits = 12; x.cd = 1; x.bits = 32'h7D4; x.mon = 32'h2BE;
      q0.push_back(x);
      x.t = t0 + 27; x.bits = 32'h348; x.mon = 32'h12C;
      q0.push_back(x);
    end
    repeat (3) @(negedge clk);
    tx_a = {4'h2, 4'h1}; rx_a = 4'hC;
    while (cyc < t0 + 27) @(negedge clk);
    @(negedge clk);
    en_a = 1'b0;
    wait_drain(0, 200);

    // DUT B, MSB first: frame 01,02,03,1F = 20'h0887F.
    start_b({5'h03, 5'h02, 5'h01}, 5'h1F, 1'b0, 1'b0, 20, 32'h0887F, 32'h0887F);
    wait_drain(1, 300);

    // DUT B: tx0 == tx2 (not adjacent) takes the error path.
    start_b({5'h01, 5'h02, 5'h01}, 5'h00, 1'b0, 1'b1, 0, 32'h0, 32'h0);
    check("nonadj_dup_done", {31'b0, done_b}, 32'd1);
    check("nonadj_dup_err", {31'b0, err_b}, 32'd1);
    wait_drain(1, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sif_address_shifter.md
Name: sif_address_shifter

Overview:
- Parametrised serial address loader for the sensor-interface analog multiplexers.
- Packs N_TX transmit addresses and one receive address into a single frame, then shifts it out over a divided SPI-style clock (spi_clk_o/spi_data_o).
- Closes each frame with a latch strobe.
- Rejects duplicate transmit addresses in capacitive mode. Sits between the measurement sequencer (en_i/done_o handshake) and the mux shift-register chain.

Parameters:
- ADDR_W, 4, width of each address field (>=1).
- N_TX, 2, number of transmit address channels (>=1).
- CLK_DIV, 1, clk_i cycles per spi_clk_o half-period (>=1).
- MSB_FIRST, 0, 0 = frame LSB shifted first, 1 = frame MSB shifted first.
- Derived: FRAME_W = (N_TX+1)*ADDR_W.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous, active-high.
- tx_add_i  in  N_TX*ADDR_W  packed tx addresses; channel k at [k*ADDR_W +: ADDR_W].
- rx_add_i  in  ADDR_W  receive address.
- en_i  in  1  start request, level; sampled in IDLE only.
- mode_i  in  1  1 = continuity check, 0 = capacitive check.
- spi_clk_o  out  1  serial clock; low outside SHIFT.
- spi_data_o  out  1  serial data.
- spi_latch_o  out  1  frame latch strobe.
- busy_o  out  1  high in SHIFT and LATCH.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  duplicate-address error flag.
- spi_reg_mon  out  FRAME_W  shift register contents (debug).

Behaviour:
- Reset (any state): state = IDLE. spi_reg = 0, err = 0, divider = 0, bit count = 0. All outputs 0.
- Frame layout: {tx[0], tx[1], ..., tx[N_TX-1], rx_add_i}, with tx[0] in the MSBs.
- Inputs are captured only on the acceptance cycle (IDLE && en_i). Later input changes are ignored.
- Duplicate error: mode_i == 0 and any pair tx[j] == tx[k] (j != k). Checked combinationally on the acceptance cycle. N_TX == 1 never errors. Continuity mode never errors.
- States: IDLE, SHIFT, LATCH, DONE.
- IDLE to DONE: en_i with duplicate error. Sets err. No frame is loaded and no clocks are issued.
- IDLE to SHIFT: en_i without error. Loads spi_reg and clears err.
- SHIFT:
  - Each bit occupies 2*CLK_DIV cycles: spi_clk_o low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - Shift happens on the last high cycle (the falling edge). Data is stable across the rising edge.
  - spi_data_o = spi_reg[0] (MSB_FIRST=0) or spi_reg[FRAME_W-1] (MSB_FIRST=1). It is valid from the first SHIFT cycle.
  - Shift direction: right for MSB_FIRST=0, left for MSB_FIRST=1. Vacated bits are zero-filled.
  - Bit counter width is $clog2(FRAME_W+1). After FRAME_W shifts, go to LATCH.
- LATCH: spi_latch_o = 1 for CLK_DIV cycles. spi_clk_o = 0. spi_data_o = 0 (register fully drained). Then go to DONE.
- DONE: done_o = 1 for exactly one cycle, then IDLE. busy_o = 0 in DONE.
- err_o: set on entry to DONE via the error path. Held until the next error-free acceptance or reset.
- Latency (accept at cycle t): SHIFT occupies t+1 .. t+FRAME_W*2*CLK_DIV. LATCH follows for CLK_DIV cycles. done_o at t+FRAME_W*2*CLK_DIV+CLK_DIV+1.
- Error path latency: done_o and err_o both high at t+1.
- en_i outside IDLE is ignored; no queuing.
- en_i held high starts a new frame on the first IDLE cycle after DONE. Minimum gap is one IDLE cycle.
- spi_reg_mon mirrors spi_reg every cycle. It retains its last value (zero after a full frame) in IDLE until the next load.
- Reset mid-frame: next cycle is IDLE with all outputs 0. No latch pulse and no done pulse are produced.

Test Plan:
- Defaults; tx0=4'hA, tx1=4'h3, rx=4'h5, mode 0; en at t.
  - Required: spi_reg_mon=12'hA35 at t+1, and 12 spi_clk_o rising edges.
  - Data bits in order: 1,0,1,0, 1,1,0,0, 0,1,0,1.
  - spi_latch_o at t+25, done_o at t+26, err_o=0.
- Defaults; tx0=tx1=4'h7, mode 0.
  - Required: done_o=1 and err_o=1 at t+1, zero spi_clk_o edges.
  - err_o stays 1 until the next valid accept, then clears.
- Same addresses, mode 1: full 12-bit frame 12'h775 shifted out, err_o=0.
- ADDR_W=5, N_TX=3, CLK_DIV=3, MSB_FIRST=1; tx={5'h01,5'h02,5'h03}, rx=5'h1F.
  - Required: 20 spi_clk_o pulses, each high 3 cycles.
  - First data bit = MSB of tx0 = 0; last four bits = 1.
  - spi_latch_o high 3 cycles, done_o at t+124.
- N_TX=3, mode 0, tx0=tx2 only (non-adjacent duplicate): error path taken.
- rst_i asserted after the 5th shift.
  - Required: outputs all 0 the next cycle; no done_o/spi_latch_o pulse.
  - A subsequent en_i runs a full, correct frame.
- en_i held high continuously: consecutive frames separated by exactly one IDLE cycle; en_i pulses during SHIFT have no effect.
